// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/threshold status and synchronous flush.
// The head word is always visible on data_o; the consumer pops on its own handshake.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned THRESHOLD  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  testmode_i,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  threshold_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESHOLD_C = CNT_W'(THRESHOLD);

  // Handshake: push_i/pop_i are requests, not valid/ready pairs. A push is
  // accepted when ~full_o, a pop when ~empty_o, both judged on the state
  // before the edge; rejected requests are dropped without any indication.

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic push_eff;
  logic pop_eff;
  logic mem_en;

  assign full_o      = (count_q == DEPTH_C);
  assign empty_o     = (count_q == '0);
  assign threshold_o = (count_q >= THRESHOLD_C);
  assign data_o      = mem_q[rd_ptr_q];

  assign push_eff = push_i & ~full_o & ~flush_i;
  assign pop_eff  = pop_i & ~empty_o & ~flush_i;

  // Storage enable is where a clock gate would sit; testmode forces it open,
  // which is harmless because mem_d equals mem_q whenever nothing is pushed.
  assign mem_en = push_eff | testmode_i;

  always_comb begin
    mem_d = mem_q;
    if (push_eff) begin
      mem_d[wr_ptr_q] = data_i;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) begin
        wr_ptr_d = (DEPTH == 1) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr_d = (DEPTH == 1) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (mem_en) begin
        mem_q <= mem_d;
      end
    end
  end

`ifndef SYNTHESIS
  localparam bit DEPTH_OK = (DEPTH > 0) && ((DEPTH & (DEPTH - 1)) == 0);
  localparam bit THR_OK   = (THRESHOLD >= 1) && (THRESHOLD <= DEPTH);

  always @(posedge clk_i) begin
    assert (DEPTH_OK) else $error("sync_fifo: DEPTH must be a power of two >= 1");
    assert (THR_OK) else $error("sync_fifo: THRESHOLD must lie in 1..DEPTH");
    if (rst_ni && !flush_i && push_i && full_o) begin
      $warning("sync_fifo: push while full dropped");
    end
    if (rst_ni && !flush_i && pop_i && empty_o) begin
      $warning("sync_fifo: pop while empty ignored");
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed vector table for the corner cases, then
// randomized traffic checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int THR   = 4;

  logic          clk;
  logic          rst_n;
  logic          testmode;
  logic          flush;
  logic          full;
  logic          empty;
  logic          thr;
  logic [DW-1:0] din;
  logic          push;
  logic [DW-1:0] dout;
  logic          pop;

  sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .THRESHOLD (THR)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .testmode_i (testmode),
    .flush_i    (flush),
    .full_o     (full),
    .empty_o    (empty),
    .threshold_o(thr),
    .data_i     (din),
    .push_i     (push),
    .data_o     (dout),
    .pop_i      (pop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          push;
    logic          pop;
    logic          flush;
    logic [DW-1:0] din;
    int            cnt;
    logic [DW-1:0] head;
    bit            chk_head;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] exp_q[$];
  int            n_vec;
  int            n_err;

  task automatic add(input logic r, input logic pu, input logic po, input logic fl,
                     input logic [DW-1:0] d, input int cnt, input logic [DW-1:0] head,
                     input bit chk);
    vec_t v;
    v.rst_n = r; v.push = pu; v.pop = po; v.flush = fl; v.din = d;
    v.cnt = cnt; v.head = head; v.chk_head = chk;
    vecs.push_back(v);
  endtask

  // scoreboard comparison; flags follow from the expected fill level
  task automatic check(input string name, input int idx, input int cnt,
                       input bit chk_head, input logic [DW-1:0] head);
    logic e_empty, e_full, e_thr;
    bit   ok;
    e_empty = (cnt == 0);
    e_full  = (cnt == DEPTH);
    e_thr   = (cnt >= THR);
    n_vec++;
    ok = (empty === e_empty) && (full === e_full) && (thr === e_thr);
    if (chk_head && dout !== head) ok = 1'b0;
    if (!ok) begin
      n_err++;
      $display("FAIL %s[%0d]: got empty=%b full=%b thr=%b data=%h, want empty=%b full=%b thr=%b data=%h (checked=%0d)",
               name, idx, empty, full, thr, dout, e_empty, e_full, e_thr, head, chk_head);
    end
  endtask

  // driver
  task automatic drive(input logic r, input logic pu, input logic po, input logic fl,
                       input logic [DW-1:0] d, input logic tm);
    rst_n = r; push = pu; pop = po; flush = fl; din = d; testmode = tm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; din = '0; testmode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset then idle
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    // fill 0x11..0x88, drop 0x99, drain in order
    for (int i = 1; i <= 8; i++) add(1, 1, 0, 0, 32'h11 * i, i, 32'h11, 1);
    add(1, 1, 0, 0, 32'h99, 8, 32'h11, 1);
    for (int k = 1; k <= 8; k++) add(1, 0, 1, 0, 0, 8 - k, 32'h11 * (k + 1), k < 8);
    // wrap-around
    for (int i = 1; i <= 5; i++) add(1, 1, 0, 0, i, i, 1, 1);
    for (int k = 1; k <= 5; k++) add(1, 0, 1, 0, 0, 5 - k, 1 + k, k < 5);
    for (int i = 0; i < 8; i++) add(1, 1, 0, 0, 32'hA0 + i, i + 1, 32'hA0, 1);
    for (int k = 1; k <= 8; k++) add(1, 0, 1, 0, 0, 8 - k, 32'hA0 + k, k < 8);
    // simultaneous push+pop with 3 entries
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 32'h31 + i, i + 1, 32'h31, 1);
    add(1, 1, 1, 0, 32'h34, 3, 32'h32, 1);
    for (int k = 1; k <= 3; k++) add(1, 0, 1, 0, 0, 3 - k, 32'h32 + k, k < 3);
    // simultaneous push+pop when empty
    add(1, 1, 1, 0, 32'h41, 1, 32'h41, 1);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    // simultaneous push+pop when full
    for (int i = 0; i < 8; i++) add(1, 1, 0, 0, 32'h50 + i, i + 1, 32'h50, 1);
    add(1, 1, 1, 0, 32'hEE, 7, 32'h51, 1);
    for (int k = 1; k <= 7; k++) add(1, 0, 1, 0, 0, 7 - k, 32'h51 + k, k < 7);
    // flush with push asserted
    for (int i = 0; i < 6; i++) add(1, 1, 0, 0, 32'h61 + i, i + 1, 32'h61, 1);
    add(1, 1, 0, 1, 32'h77, 0, 0, 0);
    add(1, 1, 0, 0, 32'h5A, 1, 32'h5A, 1);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    // reset with 5 entries stored, then pop ignored
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 32'h71 + i, i + 1, 32'h71, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 32'h12, 1, 32'h12, 1);
    add(1, 0, 1, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].din, 1'b0);
      check("vec", i, vecs[i].cnt, vecs[i].chk_head, vecs[i].head);
    end

    // randomized traffic against the queue model
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    exp_q.delete();
    check("rand_rst", 0, 0, 1, '0);
    for (int c = 0; c < 800; c++) begin
      int            pbias;
      logic          r, pu, po, fl, tm;
      logic [DW-1:0] d;
      bit            do_push, do_pop;
      pbias = ((c / 100) % 2 == 0) ? 70 : 30;
      r  = ($urandom_range(0, 199) != 0);
      fl = ($urandom_range(0, 59) == 0);
      pu = ($urandom_range(0, 99) < pbias);
      po = ($urandom_range(0, 99) < (100 - pbias));
      tm = $urandom_range(0, 1);
      d  = $urandom;
      drive(r, pu, po, fl, d, tm);
      if (!r) begin
        exp_q.delete();
      end else if (fl) begin
        exp_q.delete();
      end else begin
        do_push = pu && (exp_q.size() < DEPTH);
        do_pop  = po && (exp_q.size() > 0);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(d);
      end
      if (exp_q.size() > 0) check("rand", c, exp_q.size(), 1, exp_q[0]);
      else                  check("rand", c, 0, !r, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
